// File: rtl/reorder_buffer.sv
// reorder_buffer: circular in-order retirement buffer; allocates rename tags, captures CDB
// results, forwards ready operands to dispatch and retires/flushes in program order.
module reorder_buffer #(
   parameter int ROB_SIZE = 16,
   parameter int IDX_W = 4
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        rdy,
   input  logic        dispatch_valid,
   input  logic [4:0]  dispatch_rd,
   input  logic [1:0]  dispatch_type,
   input  logic [31:0] dispatch_pc,
   input  logic        dispatch_pred_taken,
   output logic [4:0]  alloc_tag,
   output logic        rob_full,
   input  logic [4:0]  query_tag_i,
   input  logic [4:0]  query_tag_j,
   output logic        query_ready_i,
   output logic        query_ready_j,
   output logic [31:0] query_value_i,
   output logic [31:0] query_value_j,
   input  logic        alu_cdb_valid,
   input  logic [4:0]  alu_cdb_tag,
   input  logic [31:0] alu_cdb_value,
   input  logic        alu_cdb_taken,
   input  logic [31:0] alu_cdb_target,
   input  logic        lsb_cdb_valid,
   input  logic [4:0]  lsb_cdb_tag,
   input  logic [31:0] lsb_cdb_value,
   output logic        commit_valid,
   output logic [4:0]  commit_dest,
   output logic [4:0]  commit_tag,
   output logic [31:0] commit_value,
   output logic        store_commit,
   output logic [4:0]  store_commit_tag,
   output logic        wrong_commit,
   output logic [31:0] redirect_pc,
   output logic        bp_update_valid,
   output logic [31:0] bp_update_pc,
   output logic        bp_update_taken
);
   localparam logic [5:0] SZ = 6'(ROB_SIZE);
   logic [ROB_SIZE-1:0] busy, ready, pred, taken;
   logic [4:0]  rd     [ROB_SIZE];
   logic [1:0]  kind   [ROB_SIZE];
   logic [31:0] pc     [ROB_SIZE];
   logic [31:0] target [ROB_SIZE];
   logic [31:0] value  [ROB_SIZE];
   logic [IDX_W-1:0] head, tail, ia, il, qa, qb;
   logic [IDX_W:0] count;
   logic [4:0] head_tag;
   logic alloc, commit, cv, wa, wl, is_reg, is_br, is_st, wrong;
   logic hi, hj, ai, aj, li, lj;

   function automatic logic ok(input logic [4:0] t);
      return t != 5'd0 && {1'b0, t} <= SZ;
   endfunction

   function automatic logic [IDX_W-1:0] idx(input logic [4:0] t);
      logic [4:0] m;
      m = t - 5'd1;
      return m[IDX_W-1:0];
   endfunction

   assign rob_full = count == (IDX_W+1)'(ROB_SIZE);
   assign alloc_tag = 5'(tail) + 5'd1;
   assign head_tag = 5'(head) + 5'd1;
   // wrong_commit doubles as the flush cycle: new work is dropped and the buffer empties at its end
   assign alloc = dispatch_valid && !rob_full && !wrong_commit;
   assign commit = !wrong_commit && busy[head] && ready[head];
   assign is_reg = kind[head] == 2'd0;
   assign is_br = kind[head] == 2'd1;
   assign is_st = kind[head] == 2'd2;
   assign wrong = is_br && taken[head] != pred[head];
   assign cv = commit && (is_reg || (is_br && rd[head] != 5'd0));
   assign ia = idx(alu_cdb_tag);
   assign il = idx(lsb_cdb_tag);
   assign wa = alu_cdb_valid && !wrong_commit && ok(alu_cdb_tag) && busy[ia];
   assign wl = lsb_cdb_valid && !wrong_commit && ok(lsb_cdb_tag) && busy[il];

   assign qa = idx(query_tag_i);
   assign qb = idx(query_tag_j);
   assign hi = ok(query_tag_i) && busy[qa] && ready[qa];
   assign hj = ok(query_tag_j) && busy[qb] && ready[qb];
   assign ai = alu_cdb_valid && alu_cdb_tag == query_tag_i;
   assign aj = alu_cdb_valid && alu_cdb_tag == query_tag_j;
   assign li = lsb_cdb_valid && lsb_cdb_tag == query_tag_i;
   assign lj = lsb_cdb_valid && lsb_cdb_tag == query_tag_j;
   assign query_ready_i = query_tag_i == 5'd0 || hi || ai || li;
   assign query_ready_j = query_tag_j == 5'd0 || hj || aj || lj;
   assign query_value_i = query_tag_i == 5'd0 ? '0 : hi ? value[qa] : ai ? alu_cdb_value :
                          li ? lsb_cdb_value : '0;
   assign query_value_j = query_tag_j == 5'd0 ? '0 : hj ? value[qb] : aj ? alu_cdb_value :
                          lj ? lsb_cdb_value : '0;

   always_ff @(posedge clk) begin
      if (rst) begin
         busy <= '0;
         ready <= '0;
         head <= '0;
         tail <= '0;
         count <= '0;
         commit_valid <= 1'b0;
         commit_dest <= '0;
         commit_tag <= '0;
         commit_value <= '0;
         store_commit <= 1'b0;
         store_commit_tag <= '0;
         wrong_commit <= 1'b0;
         redirect_pc <= '0;
         bp_update_valid <= 1'b0;
         bp_update_pc <= '0;
         bp_update_taken <= 1'b0;
      end else if (rdy) begin
         commit_valid <= cv;
         commit_dest <= cv ? rd[head] : '0;
         commit_tag <= cv ? head_tag : '0;
         commit_value <= cv ? value[head] : '0;
         store_commit <= commit && is_st;
         store_commit_tag <= commit && is_st ? head_tag : '0;
         wrong_commit <= commit && wrong;
         redirect_pc <= commit && wrong ? target[head] : '0;
         bp_update_valid <= commit && is_br;
         bp_update_pc <= commit && is_br ? pc[head] : '0;
         bp_update_taken <= commit && is_br && taken[head];
         if (wrong_commit) begin
            busy <= '0;
            ready <= '0;
            head <= '0;
            tail <= '0;
            count <= '0;
         end else begin
            // LSB first so the ALU result wins when both name the same tag
            if (wl) begin
               ready[il] <= 1'b1;
               value[il] <= lsb_cdb_value;
            end
            if (wa) begin
               ready[ia] <= 1'b1;
               value[ia] <= alu_cdb_value;
               taken[ia] <= alu_cdb_taken;
               target[ia] <= alu_cdb_target;
            end
            if (commit) begin
               busy[head] <= 1'b0;
               ready[head] <= 1'b0;
               head <= head + IDX_W'(1);
            end
            if (alloc) begin
               busy[tail] <= 1'b1;
               ready[tail] <= 1'b0;
               rd[tail] <= dispatch_rd;
               kind[tail] <= dispatch_type;
               pc[tail] <= dispatch_pc;
               pred[tail] <= dispatch_pred_taken;
               tail <= tail + IDX_W'(1);
            end
            count <= count + (IDX_W+1)'(alloc) - (IDX_W+1)'(commit);
         end
      end
   end
endmodule

// File: doc/reorder_buffer.md
Name: reorder_buffer

Overview:
- Circular in-order retirement buffer of the Tomasulo core.
- Sits between the dispatcher and execution units (CDB) and the register file / load-store buffer.
- Allocates a rename tag per dispatched instruction, captures results from the CDB, forwards ready values to dispatch, and retires in program order.
- Drives the register-file commit port and issues the global flush on branch misprediction.

Parameters:
- ROB_SIZE, 16, number of entries; power of two, at most 16; tag = index+1, so tag 0 always means "no dependency".
- IDX_W, 4, log2(ROB_SIZE).

Ports:
- clk  in  1  clock
- rst  in  1  reset, synchronous, active-high
- rdy  in  1  global enable; when low all state and outputs hold
- dispatch_valid  in  1  allocate one entry this cycle
- dispatch_rd  in  5  destination register (0 = none)
- dispatch_type  in  2  0 = reg-write, 1 = branch, 2 = store
- dispatch_pc  in  32  instruction PC
- dispatch_pred_taken  in  1  predictor decision (branches)
- alloc_tag  out  5  tag that the next allocation receives (tail+1), combinational
- rob_full  out  1  count == ROB_SIZE, combinational
- query_tag_i / query_tag_j  in  5  operand tags from the register file
- query_ready_i / query_ready_j  out  1  value for that tag is available
- query_value_i / query_value_j  out  32  the value
- alu_cdb_valid  in  1  ALU result broadcast
- alu_cdb_tag  in  5
- alu_cdb_value  in  32  rd value (pc+4 for jal/jalr)
- alu_cdb_taken  in  1  actual branch outcome
- alu_cdb_target  in  32  correct next PC when the branch is mispredicted
- lsb_cdb_valid  in  1  load result / store address ready
- lsb_cdb_tag  in  5
- lsb_cdb_value  in  32
- commit_valid  out  1  register-file write pulse
- commit_dest  out  5  destination register
- commit_tag  out  5  tag of the retiring entry
- commit_value  out  32  value written
- store_commit  out  1  pulse: head store may write memory
- store_commit_tag  out  5
- wrong_commit  out  1  flush pulse
- redirect_pc  out  32  fetch restart PC, valid with wrong_commit
- bp_update_valid  out  1  branch retired
- bp_update_pc  out  32
- bp_update_taken  out  1

Behaviour:
- Entry fields: busy, ready, rd, type, pc, pred_taken, taken, target, value.
- Pointers: head, tail (IDX_W bits, wrap modulo ROB_SIZE); count 0..ROB_SIZE.
- Reset: all busy/ready cleared; head = tail = count = 0; every registered output 0. The same applies on reset mid-operation.
- Allocation: when dispatch_valid && !rob_full && !flush, write entry[tail] with busy=1, ready=0, then tail+1 and count+1.
  - Dispatch while full is ignored; the dispatcher must gate on rob_full.
- Writeback: a CDB valid with tag t sets entry[t-1].ready=1 and stores value, plus taken/target for ALU results.
  - Both CDBs may write in the same cycle.
  - Writes to non-busy entries are ignored.
- Query: query_ready_x = 1 when any of the following holds for the queried tag:
  - tag == 0 (value 0);
  - entry busy && ready (entry value);
  - same-cycle CDB match (CDB value; ALU has priority over LSB if both match).
- Commit: evaluated every rdy cycle when entry[head] is busy && ready. Outputs are registered and pulse for exactly one cycle. On commit, head+1 and count-1.
  - reg-write: commit_valid=1, commit_dest=rd, commit_tag=head+1, commit_value=value.
  - store: store_commit=1, store_commit_tag=head+1; commit_valid=0.
  - branch: bp_update_* pulse. commit_valid=1 only if rd != 0 (jal/jalr).
    - If taken != pred_taken, wrong_commit=1 and redirect_pc=target in the same output cycle.
- At most one commit per cycle.
- An entry made ready by the CDB in cycle N commits at the earliest in cycle N+1.
- Flush: in the cycle after the commit that raises wrong_commit, all entries are cleared and head = tail = count = 0.
  - Any dispatch or CDB write arriving while wrong_commit is high is dropped.
- Simultaneous alloc + commit: count is unchanged.
- rob_full is evaluated before the commit, so alloc is refused when full even if a commit happens that cycle.
- Wrap-around: tail from ROB_SIZE-1 goes to 0. Tags never take the value 0.
- rdy low: no pointer, entry or output changes.

Test Plan:
- Reset, then dispatch rd=5 (tag 1); ALU CDB tag1 value 0x2A -> next cycle commit_valid=1, dest=5, tag=1, value=0x2A, single-cycle pulse.
- Dispatch 16 reg-writes -> rob_full=1 and a 17th dispatch ignored. Commit one -> rob_full=0; next alloc_tag=1, confirming wrap.
- Dispatch tags 1,2; CDB completes tag2 first, then tag1 -> commits occur in order: tag1, then tag2.
- query_tag_i=3 while lsb_cdb tag3 value 0x77 in the same cycle -> query_ready_i=1, query_value_i=0x77.
- Branch tag1 pred_taken=0, ALU taken=1, target 0x1040, a younger entry already dispatched -> wrong_commit=1, redirect_pc=0x1040, bp_update_taken=1; next cycle count=0 and alloc_tag=1.
- Store entry ready at head -> store_commit=1 with its tag and commit_valid=0. Then rdy held low for 3 cycles -> outputs and pointers frozen.
